fp_add_sched: RTL and testbench

Two-requester scheduler that shares one combinational single-precision adder (`float_adder`) between two AXI-stream operand sources. It round-robin arbitrates between the sources and registers the operands and result in a 2-stage pipeline. Results are returned on one AXI-stream master tagged with the source channel. It sits between the AXI-stream input registers and downstream result consumers.

---
 rtl/fp_add_sched_pkg.sv | 16 +
 rtl/fp_add_sched_if.sv | 26 ++
 rtl/float_adder.sv | 33 +++
 rtl/fp_rr_arb2.sv | 25 ++
 rtl/fp_add_sched.sv | 91 +++++++++
 tb/tb_fp_add_sched.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/fp_add_sched_pkg.sv
// Shared types and constants for the two-channel FP add scheduler.
package fp_sched_pkg;
    localparam int CH_NUM = 2;
    localparam int FP_W   = 32;

    localparam logic [FP_W-1:0] FP_ONE = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO = 32'h4000_0000;

    typedef logic [$clog2(CH_NUM)-1:0] tid_t;

    typedef struct packed {
        logic            valid;
        tid_t            tid;
        logic [FP_W-1:0] data;
    } stage_t;
endpackage

// File: rtl/fp_add_sched_if.sv
// Operand and result AXI-stream bundle; slave is the scheduler's view.
interface fp_add_sched_if #(parameter int DATA = 32);
    logic            s0_axis_valid, s0_axis_ready;
    logic [DATA-1:0] s0_axis_a, s0_axis_b;
    logic            s1_axis_valid, s1_axis_ready;
    logic [DATA-1:0] s1_axis_a, s1_axis_b;
    logic            m_axis_valid, m_axis_ready;
    logic [DATA-1:0] m_axis_data;
    logic            m_axis_tid;

    modport slave (
        input  s0_axis_valid, s0_axis_a, s0_axis_b,
        input  s1_axis_valid, s1_axis_a, s1_axis_b,
        input  m_axis_ready,
        output s0_axis_ready, s1_axis_ready,
        output m_axis_valid, m_axis_data, m_axis_tid
    );

    modport master (
        output s0_axis_valid, s0_axis_a, s0_axis_b,
        output s1_axis_valid, s1_axis_a, s1_axis_b,
        output m_axis_ready,
        input  s0_axis_ready, s1_axis_ready,
        input  m_axis_valid, m_axis_data, m_axis_tid
    );
endinterface

// File: rtl/float_adder.sv
// Combinational magnitude-only single-precision adder: sign follows A,
// mantissas are truncated, no special values.
module float_adder (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Out
);
    logic [7:0]  ea, eb, diff, e_big;
    logic [23:0] m_big, m_sml;
    logic [24:0] sum;

    always_comb begin
        ea = A[30:23];
        eb = B[30:23];
        if (ea >= eb) begin
            diff  = ea - eb;
            e_big = ea;
            m_big = {1'b1, A[22:0]};
            m_sml = {1'b1, B[22:0]} >> diff;
        end else begin
            diff  = eb - ea;
            e_big = eb;
            m_big = {1'b1, B[22:0]};
            m_sml = {1'b1, A[22:0]} >> diff;
        end
        sum = {1'b0, m_big} + {1'b0, m_sml};
        // a carry out of the hidden bit renormalises by one place
        if (sum[24])
            Out = {A[31], e_big + 8'd1, sum[23:1]};
        else
            Out = {A[31], e_big, sum[22:0]};
    end
endmodule

// File: rtl/fp_rr_arb2.sv
// Two-input round-robin arbiter; pointer favours the channel not served last.
module fp_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant      = 2'b00;
            grant[ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (advance && |grant)
            ptr <= grant[0];
    end
endmodule

// File: rtl/fp_add_sched.sv
// Shares one float_adder between two operand streams through a
// two-stage (operands, result) pipeline with round-robin arbitration.
module fp_add_sched
    import fp_sched_pkg::*;
#(
    parameter int DATA  = 32,
    parameter int CNT_W = 16
) (
    input  logic             axis_clk,
    input  logic             axis_reset,
    fp_add_sched_if.slave    s,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1,
    output logic             busy
);
    logic            en;
    logic            v1;
    tid_t            tid1;
    logic [DATA-1:0] a1, b1;
    stage_t          s2;
    logic [31:0]     sum;
    logic [1:0]      req, grant;
    logic            adv1, adv2, take;

    // en keeps readies low until the first edge after reset release
    assign req  = {s.s1_axis_valid, s.s0_axis_valid} & {2{en}};
    assign adv2 = !s2.valid | s.m_axis_ready;
    assign adv1 = !v1 | adv2;
    assign take = adv1 & |grant;

    fp_rr_arb2 u_arb (
        .clk    (axis_clk),
        .rst_n  (axis_reset),
        .req    (req),
        .advance(adv1),
        .grant  (grant)
    );

    float_adder u_add (
        .A  (a1),
        .B  (b1),
        .Out(sum)
    );

    assign s.s0_axis_ready = grant[0] & adv1;
    assign s.s1_axis_ready = grant[1] & adv1;
    assign s.m_axis_valid  = s2.valid;
    assign s.m_axis_data   = s2.data;
    assign s.m_axis_tid    = s2.tid;
    assign busy            = v1 | s2.valid;

    always_ff @(posedge axis_clk or negedge axis_reset) begin
        if (!axis_reset) begin
            en   <= 1'b0;
            v1   <= 1'b0;
            tid1 <= '0;
            a1   <= '0;
            b1   <= '0;
            s2   <= '0;
        end else begin
            en <= 1'b1;
            if (adv1) begin
                v1 <= take;
                if (take) begin
                    tid1 <= grant[1];
                    a1   <= grant[1] ? s.s1_axis_a : s.s0_axis_a;
                    b1   <= grant[1] ? s.s1_axis_b : s.s0_axis_b;
                end
            end
            if (adv2) begin
                s2.valid <= v1;
                if (v1) begin
                    s2.tid  <= tid1;
                    s2.data <= sum;
                end
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_reset) begin
        if (!axis_reset) begin
            done_cnt0 <= '0;
            done_cnt1 <= '0;
        end else if (s2.valid && s.m_axis_ready) begin
            if (s2.tid == 1'b1)
                done_cnt1 <= done_cnt1 + 1'b1;
            else
                done_cnt0 <= done_cnt0 + 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_add_sched.sv
// Directed bench for fp_add_sched: single ops, fairness, backpressure,
// mid-flight reset and 4-bit counter wrap.
module tb_fp_add_sched;
    import fp_sched_pkg::*;

    localparam int CW = 4;
    localparam logic [31:0] FP_1P5   = 32'h3FC0_0000;
    localparam logic [31:0] FP_HALF  = 32'h3F00_0000;
    localparam logic [31:0] FP_THREE = 32'h4040_0000;

    logic          axis_clk   = 1'b0;
    logic          axis_reset = 1'b0;
    logic [CW-1:0] done_cnt0, done_cnt1;
    logic          busy;
    int            checks = 0;
    int            errors = 0;

    fp_add_sched_if #(.DATA(32)) bus ();

    fp_add_sched #(.DATA(32), .CNT_W(CW)) dut (
        .axis_clk  (axis_clk),
        .axis_reset(axis_reset),
        .s         (bus),
        .done_cnt0 (done_cnt0),
        .done_cnt1 (done_cnt1),
        .busy      (busy)
    );

    always #5 axis_clk = ~axis_clk;

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    // one isolated operation on an idle pipeline, drained with ready high
    task automatic send_one(input string tag, input logic ch, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res,
                            input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        bus.m_axis_ready = 1'b1;
        if (ch) begin
            bus.s1_axis_valid = 1'b1; bus.s1_axis_a = a; bus.s1_axis_b = b;
        end else begin
            bus.s0_axis_valid = 1'b1; bus.s0_axis_a = a; bus.s0_axis_b = b;
        end
        #1;
        chk({tag, "_rdy"}, ch ? bus.s1_axis_ready : bus.s0_axis_ready, 1);
        step();
        bus.s0_axis_valid = 1'b0;
        bus.s1_axis_valid = 1'b0;
        #1;
        chk({tag, "_vld_s1"}, bus.m_axis_valid, 0);
        chk({tag, "_busy"}, busy, 1);
        step();
        chk({tag, "_vld"}, bus.m_axis_valid, 1);
        chk({tag, "_data"}, bus.m_axis_data, res);
        chk({tag, "_tid"}, bus.m_axis_tid, ch);
        step();
        chk({tag, "_vld_done"}, bus.m_axis_valid, 0);
        chk({tag, "_cnt0"}, done_cnt0, c0);
        chk({tag, "_cnt1"}, done_cnt1, c1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        bus.s0_axis_valid = 1'b1;
        bus.s0_axis_a = FP_ONE; bus.s0_axis_b = FP_ONE;
        bus.s1_axis_valid = 1'b0;
        bus.s1_axis_a = '0; bus.s1_axis_b = '0;
        bus.m_axis_ready = 1'b0;

        // reset state
        #12;
        chk("rst_mvalid", bus.m_axis_valid, 0);
        chk("rst_mdata", bus.m_axis_data, 0);
        chk("rst_mtid", bus.m_axis_tid, 0);
        chk("rst_rdy0", bus.s0_axis_ready, 0);
        chk("rst_rdy1", bus.s1_axis_ready, 0);
        chk("rst_cnt0", done_cnt0, 0);
        chk("rst_cnt1", done_cnt1, 0);
        chk("rst_busy", busy, 0);
        bus.s0_axis_valid = 1'b0;
        @(negedge axis_clk);
        axis_reset = 1'b1;
        step();

        send_one("one_plus_one", 1'b0, FP_ONE, FP_ONE, FP_TWO, 4'd1, 4'd0);
        send_one("two_plus_one", 1'b0, FP_TWO, FP_ONE, FP_THREE, 4'd2, 4'd0);
        send_one("align_carry", 1'b1, FP_1P5, FP_HALF, FP_TWO, 4'd2, 4'd1);

        // fairness: ch0 yields 2.0, ch1 yields 3.0
        bus.s0_axis_a = FP_ONE; bus.s0_axis_b = FP_ONE;
        bus.s1_axis_a = FP_TWO; bus.s1_axis_b = FP_ONE;
        bus.m_axis_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.s0_axis_valid = (i < 8);
            bus.s1_axis_valid = (i < 8);
            #1;
            if (i < 8) begin
                chk("fair_rdy0", bus.s0_axis_ready, (i % 2 == 0));
                chk("fair_rdy1", bus.s1_axis_ready, (i % 2 == 1));
            end
            chk("fair_vld", bus.m_axis_valid, (i >= 2));
            if (i >= 2) begin
                chk("fair_tid", bus.m_axis_tid, (i - 2) % 2);
                chk("fair_data", bus.m_axis_data, ((i - 2) % 2 == 1) ? FP_THREE : FP_TWO);
            end
            step();
        end
        #1;
        chk("fair_cnt0", done_cnt0, 6);
        chk("fair_cnt1", done_cnt1, 5);
        chk("fair_idle", busy, 0);

        // backpressure: two entries fill the pipe, then it stalls
        for (int i = 0; i < 8; i++) begin
            bus.m_axis_ready  = (i >= 5);
            bus.s0_axis_valid = (i < 5);
            bus.s1_axis_valid = (i < 5);
            #1;
            if (i == 0) begin
                chk("bp_rdy0_a", bus.s0_axis_ready, 1);
                chk("bp_rdy1_a", bus.s1_axis_ready, 0);
            end else if (i == 1) begin
                chk("bp_rdy0_b", bus.s0_axis_ready, 0);
                chk("bp_rdy1_b", bus.s1_axis_ready, 1);
            end else if (i < 5) begin
                chk("bp_rdy0_full", bus.s0_axis_ready, 0);
                chk("bp_rdy1_full", bus.s1_axis_ready, 0);
                chk("bp_hold_vld", bus.m_axis_valid, 1);
                chk("bp_hold_data", bus.m_axis_data, FP_TWO);
                chk("bp_hold_tid", bus.m_axis_tid, 0);
                chk("bp_busy", busy, 1);
            end else if (i == 5) begin
                chk("bp_drain0_vld", bus.m_axis_valid, 1);
                chk("bp_drain0_tid", bus.m_axis_tid, 0);
            end else if (i == 6) begin
                chk("bp_drain1_vld", bus.m_axis_valid, 1);
                chk("bp_drain1_tid", bus.m_axis_tid, 1);
                chk("bp_drain1_data", bus.m_axis_data, FP_THREE);
            end else begin
                chk("bp_empty_vld", bus.m_axis_valid, 0);
                chk("bp_empty_busy", busy, 0);
                chk("bp_cnt0", done_cnt0, 7);
                chk("bp_cnt1", done_cnt1, 6);
            end
            if (i < 7) step();
        end

        // reset with both stages full
        bus.m_axis_ready = 1'b0;
        bus.s0_axis_valid = 1'b1;
        step();
        step();
        bus.s0_axis_valid = 1'b0;
        #1;
        chk("mid_busy", busy, 1);
        chk("mid_vld", bus.m_axis_valid, 1);
        bus.s0_axis_valid = 1'b1;
        #2;
        axis_reset = 1'b0;
        #1;
        chk("mid_rst_vld", bus.m_axis_valid, 0);
        chk("mid_rst_data", bus.m_axis_data, 0);
        chk("mid_rst_tid", bus.m_axis_tid, 0);
        chk("mid_rst_cnt0", done_cnt0, 0);
        chk("mid_rst_cnt1", done_cnt1, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy0", bus.s0_axis_ready, 0);
        bus.s0_axis_valid = 1'b0;
        bus.m_axis_ready = 1'b1;
        @(negedge axis_clk);
        axis_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_vld", bus.m_axis_valid, 0);
            chk("post_rst_busy", busy, 0);
        end

        // 17 ch0 results through a 4-bit counter
        bus.s0_axis_a = FP_ONE; bus.s0_axis_b = FP_ONE;
        for (int i = 0; i < 19; i++) begin
            bus.s0_axis_valid = (i < 17);
            #1;
            if (i == 18) chk("wrap_zero", done_cnt0, 0);
            step();
        end
        #1;
        chk("wrap_cnt0", done_cnt0, 1);
        chk("wrap_cnt1", done_cnt1, 0);
        chk("wrap_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
